// File: rtl/dut2vip_axis_if.sv
// AXI-Stream beat bundle between the dut2vip transmitter and the XDMA C2H sink.
interface dut2vip_axis_if #(
   parameter int C_DATA_WIDTH = 128
);
   logic [C_DATA_WIDTH-1:0]   tdata;
   logic                      tvalid;
   logic                      tready;
   logic [C_DATA_WIDTH/8-1:0] tkeep;
   logic                      tlast;

   modport master (
      output tdata,
      output tvalid,
      output tkeep,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tkeep,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/dut2vip_axis_tx.sv
// Snapshots dut2vip_bus on request and streams it as one AXIS packet toward XDMA C2H.
// Optional header beat per packet when DUT2VIP_TX_HDR_EN is defined.
module dut2vip_axis_tx #(
   parameter int C_DATA_WIDTH      = 128,
   parameter int DUT2VIP_WORDS_NUM = 16,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                                      dut_clk,
   input  logic                                      dut_resetn,
   input  logic                                      snap_req,
   input  logic [C_DATA_WIDTH*DUT2VIP_WORDS_NUM-1:0] dut2vip_bus,
   dut2vip_axis_if.master                            m_axis,
   output logic                                      busy,
   output logic                                      req_overflow,
   output logic [CNT_WIDTH-1:0]                      pkt_cnt
);

   localparam int BUS_W = C_DATA_WIDTH * DUT2VIP_WORDS_NUM;
`ifdef DUT2VIP_TX_HDR_EN
   localparam int HDR_BEATS = 1;
`else
   localparam int HDR_BEATS = 0;
`endif
   localparam int BEATS_N = DUT2VIP_WORDS_NUM + HDR_BEATS;
   localparam int IDX_W   = (BEATS_N > 1) ? $clog2(BEATS_N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS_N - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                  state;
   logic                    pending;
   logic [IDX_W-1:0]        beat_idx;
   logic [BUS_W-1:0]        shadow;
   logic [C_DATA_WIDTH-1:0] tdata_r;
   logic                    tvalid_r;
   logic                    tlast_r;

   logic                    hs;
   logic                    last_hs;
   logic                    start;
   logic [CNT_WIDTH-1:0]    cnt_next;
   logic [C_DATA_WIDTH-1:0] first_data;
   logic [C_DATA_WIDTH-1:0] next_data;

   function automatic logic [C_DATA_WIDTH-1:0] word_sel(input logic [BUS_W-1:0] b,
                                                        input int unsigned       w);
      return b[w*C_DATA_WIDTH +: C_DATA_WIDTH];
   endfunction

`ifdef DUT2VIP_TX_HDR_EN
   function automatic logic [C_DATA_WIDTH-1:0] hdr_beat(input logic [CNT_WIDTH-1:0] cnt);
      logic [C_DATA_WIDTH-1:0] h;
      h        = '0;
      h[15:0]  = 16'(DUT2VIP_WORDS_NUM);
      h[31:16] = 16'(cnt);
      return h;
   endfunction
`endif

   // A new packet starts from IDLE on request, or back-to-back at the final
   // handshake when a request is pending or arrives in that same cycle.
   always_comb begin
      hs       = tvalid_r & m_axis.tready;
      last_hs  = hs & tlast_r;
      start    = (state == IDLE) ? snap_req : (last_hs & (pending | snap_req));
      cnt_next = last_hs ? pkt_cnt + CNT_WIDTH'(1) : pkt_cnt;
`ifdef DUT2VIP_TX_HDR_EN
      first_data = hdr_beat(cnt_next);
`else
      first_data = word_sel(dut2vip_bus, 0);
`endif
      next_data = word_sel(shadow, int'(beat_idx) + 1 - HDR_BEATS);
   end

   always_ff @(posedge dut_clk or negedge dut_resetn) begin
      if (!dut_resetn) begin
         state        <= IDLE;
         pending      <= 1'b0;
         beat_idx     <= '0;
         tdata_r      <= '0;
         tvalid_r     <= 1'b0;
         tlast_r      <= 1'b0;
         req_overflow <= 1'b0;
         pkt_cnt      <= '0;
      end else begin
         pkt_cnt <= cnt_next;

         if (start) begin
            state    <= SEND;
            tvalid_r <= 1'b1;
            tdata_r  <= first_data;
            tlast_r  <= (LAST_IDX == '0);
            beat_idx <= '0;
         end else if (last_hs) begin
            state    <= IDLE;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
         end else if (hs) begin
            beat_idx <= beat_idx + IDX_W'(1);
            tdata_r  <= next_data;
            tlast_r  <= ((beat_idx + IDX_W'(1)) == LAST_IDX);
         end

         // One request can wait behind the current packet; any further one is dropped.
         if (state == SEND) begin
            if (last_hs) begin
               pending <= 1'b0;
               if (pending && snap_req) req_overflow <= 1'b1;
            end else if (snap_req) begin
               if (pending) req_overflow <= 1'b1;
               else         pending      <= 1'b1;
            end
         end
      end
   end

   // The snapshot only needs to be valid while a packet is being sent.
   always_ff @(posedge dut_clk) begin
      if (start) shadow <= dut2vip_bus;
   end

   assign m_axis.tdata  = tdata_r;
   assign m_axis.tvalid = tvalid_r;
   assign m_axis.tlast  = tlast_r;
   assign m_axis.tkeep  = '1;
   assign busy          = (state != IDLE) | pending;

endmodule

// File: tb/tb_dut2vip_axis_tx.sv
// Directed bench for dut2vip_axis_tx: single packet, backpressure, pending,
// coincident request, overflow and mid-packet reset.
module tb_dut2vip_axis_tx;
  localparam int DW = 128;
  localparam int WN = 4;
  localparam int CW = 16;
`ifdef DUT2VIP_TX_HDR_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic             dut_clk     = 1'b0;
  logic             dut_resetn  = 1'b0;
  logic             snap_req    = 1'b0;
  logic [DW*WN-1:0] dut2vip_bus = '0;
  logic             busy;
  logic             req_overflow;
  logic [CW-1:0]    pkt_cnt;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    first_vld, last_iter, gaps;
  logic [31:0] stall;

  dut2vip_axis_if #(.C_DATA_WIDTH(DW)) m_axis ();

  dut2vip_axis_tx #(
    .C_DATA_WIDTH      (DW),
    .DUT2VIP_WORDS_NUM (WN),
    .CNT_WIDTH         (CW)
  ) dut (
    .dut_clk      (dut_clk),
    .dut_resetn   (dut_resetn),
    .snap_req     (snap_req),
    .dut2vip_bus  (dut2vip_bus),
    .m_axis       (m_axis),
    .busy         (busy),
    .req_overflow (req_overflow),
    .pkt_cnt      (pkt_cnt)
  );

  always #5 dut_clk = ~dut_clk;

  initial begin
    #200000;
    errors++;
    $error("FAIL timeout: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [31:0] base, input int i);
    return {4{base + 32'(i)}};
  endfunction

  task automatic set_bus(input logic [31:0] base);
    for (int i = 0; i < WN; i++) dut2vip_bus[i*DW +: DW] = word_of(base, i);
  endtask

  task automatic push_pkt(input logic [31:0] base, input logic [15:0] cnt);
    beat_t b;
`ifdef DUT2VIP_TX_HDR_EN
    b.data = {96'h0, cnt, 16'd4};
    b.last = 1'b0;
    exp_q.push_back(b);
`endif
    for (int i = 0; i < WN; i++) begin
      b.data = word_of(base, i);
      b.last = (i == WN - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic step;
    @(posedge dut_clk);
    #1;
  endtask

  // Drives one iteration per clock; beats are matched in order against exp_q.
  task automatic run(input int ncyc, input logic [31:0] req_mask, input logic [31:0] stall_mask,
                     input int chg_cyc, input logic [31:0] chg_base,
                     output int fv, output int li, output int gp);
    logic  held;
    beat_t b;
    held = 1'b0;
    fv   = -1;
    li   = -1;
    gp   = 0;
    for (int i = 0; i < ncyc; i++) begin
      snap_req      = req_mask[i];
      m_axis.tready = ~stall_mask[i];
      if (i == chg_cyc) set_bus(chg_base);
      if (held) chk("hold_valid", m_axis.tvalid, 1'b1);
      if (m_axis.tvalid) begin
        if (fv < 0) fv = i;
        chk("extra_beat", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          b = exp_q[0];
          chk("tdata", m_axis.tdata, b.data);
          chk("tlast", m_axis.tlast, b.last);
          chk("tkeep", m_axis.tkeep, 16'hFFFF);
          if (m_axis.tready) begin
            void'(exp_q.pop_front());
            if (b.last) li = i;
          end
        end
      end else if (fv >= 0 && exp_q.size() > 0) begin
        gp++;
      end
      held = m_axis.tvalid & ~m_axis.tready;
      step();
    end
    snap_req      = 1'b0;
    m_axis.tready = 1'b1;
    chk("beats_left", exp_q.size(), 0);
  endtask

  initial begin
    m_axis.tready = 1'b1;
    for (int i = 0; i < 32; i++) stall[i] = (i % 3 != 0);

    // Reset values
    step();
    step();
    chk("rst_tvalid", m_axis.tvalid, 1'b0);
    chk("rst_tlast", m_axis.tlast, 1'b0);
    chk("rst_tdata", m_axis.tdata, 128'h0);
    chk("rst_tkeep", m_axis.tkeep, 16'hFFFF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", req_overflow, 1'b0);
    chk("rst_cnt", pkt_cnt, 16'd0);
    dut_resetn = 1'b1;
    step();
    step();

    // Single packet, full throughput
    set_bus(32'hA0);
    push_pkt(32'hA0, 16'd0);
    run(10, 32'h1, 32'h0, -1, 32'h0, first_vld, last_iter, gaps);
    chk("t1_latency", first_vld, 1);
    chk("t1_last_iter", last_iter, NB);
    chk("t1_gaps", gaps, 0);
    chk("t1_cnt", pkt_cnt, 16'd1);
    chk("t1_busy", busy, 1'b0);

    // Backpressure 1,0,0,1,...
    set_bus(32'hC0);
    push_pkt(32'hC0, 16'd1);
    run(24, 32'h1, stall, -1, 32'h0, first_vld, last_iter, gaps);
    chk("t2_cnt", pkt_cnt, 16'd2);
    chk("t2_busy", busy, 1'b0);

    // Pending request during beat 1; second packet snapshots the new bus
    set_bus(32'hA0);
    push_pkt(32'hA0, 16'd2);
    push_pkt(32'hB0, 16'd3);
    run(16, 32'h5, 32'h0, 2, 32'hB0, first_vld, last_iter, gaps);
    chk("t3_gaps", gaps, 0);
    chk("t3_last_iter", last_iter, 2*NB);
    chk("t3_cnt", pkt_cnt, 16'd4);
    chk("t3_ovf", req_overflow, 1'b0);

    // Request coincident with the final handshake
    set_bus(32'hA0);
    push_pkt(32'hA0, 16'd4);
    push_pkt(32'hB0, 16'd5);
    run(16, 32'h1 | (32'h1 << NB), 32'h0, NB, 32'hB0, first_vld, last_iter, gaps);
    chk("t4_gaps", gaps, 0);
    chk("t4_last_iter", last_iter, 2*NB);
    chk("t4_cnt", pkt_cnt, 16'd6);
    chk("t4_ovf", req_overflow, 1'b0);

    // Three requests in one packet: one pending, one dropped
    set_bus(32'hA0);
    push_pkt(32'hA0, 16'd6);
    push_pkt(32'hA0, 16'd7);
    run(18, 32'hD, 32'h0, -1, 32'h0, first_vld, last_iter, gaps);
    chk("t5_ovf", req_overflow, 1'b1);
    chk("t5_cnt", pkt_cnt, 16'd8);
    chk("t5_busy", busy, 1'b0);

    // Reset mid-packet, then a clean packet
    set_bus(32'hC0);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("t6_vld_before", m_axis.tvalid, 1'b1);
    chk("t6_busy_before", busy, 1'b1);
    step();
    #2 dut_resetn = 1'b0;
    #1;
    chk("t6_vld_async", m_axis.tvalid, 1'b0);
    chk("t6_cnt_rst", pkt_cnt, 16'd0);
    chk("t6_ovf_rst", req_overflow, 1'b0);
    chk("t6_busy_rst", busy, 1'b0);
    step();
    dut_resetn = 1'b1;
    step();
    chk("t6_idle_after", m_axis.tvalid, 1'b0);
    set_bus(32'hD0);
    push_pkt(32'hD0, 16'd0);
    run(10, 32'h1, 32'h0, -1, 32'h0, first_vld, last_iter, gaps);
    chk("t6_latency", first_vld, 1);
    chk("t6_last_iter", last_iter, NB);
    chk("t6_cnt", pkt_cnt, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
